// File: rtl/cpu_addr_seq.sv
// rtl/cpu_addr_seq.sv - 6502-family effective-address sequencer
// Walks operand/pointer fetch cycles for the addressing mode and produces the effective address.
module cpu_addr_seq #(
  parameter int ADDR_W       = 16,
  parameter bit ZP_WRAP      = 1'b1,
  parameter bit PAGE_PENALTY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic              store,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        d_in,
  output logic [ADDR_W-1:0] addr,
  output logic              pc_inc,
  output logic              busy,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_valid,
  output logic              page_cross
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_INDEX, S_PTR_LO, S_PTR_HI, S_FIX, S_DONE
  } state_t;

  localparam logic [2:0] M_INX = 3'b000;
  localparam logic [2:0] M_ZPG = 3'b001;
  localparam logic [2:0] M_IMM = 3'b010;
  localparam logic [2:0] M_ABS = 3'b011;
  localparam logic [2:0] M_INY = 3'b100;
  localparam logic [2:0] M_ZPX = 3'b101;
  localparam logic [2:0] M_ABX = 3'b111;

  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic              store_q, store_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [7:0]        lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
  logic [ADDR_W-1:0] pcl_q, pcl_d, ea_q, ea_d;
  logic              pcx_q, pcx_d;

  logic [ADDR_W-1:0] addr_c;
  logic              pc_inc_c, ea_valid_c;
  logic [7:0]        idx, base_lo, hi_sel;
  logic [8:0]        idx_sum;
  logic              carry, need_fix;
  logic [ADDR_W-1:0] idx_ea;

  // Zero-page sum; with ZP_WRAP=0 the carry lands in addr[8].
  function automatic logic [ADDR_W-1:0] zp_addr(input logic [7:0] a, input logic [7:0] b,
                                                input logic c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
    zp_addr = '0;
    if (ZP_WRAP) zp_addr[7:0] = s[7:0];
    else         zp_addr[8:0] = s;
  endfunction

  function automatic logic [ADDR_W-1:0] wide16(input logic [15:0] v);
    wide16 = '0;
    wide16[15:0] = v;
  endfunction

  // Indexed base: INY indexes the pointer, ABX/ABY the operand; high byte is on the bus until FIX.
  always_comb begin
    idx      = (mode_q == M_ABX) ? x_q : y_q;
    base_lo  = (mode_q == M_INY) ? ptr_q : lo_q;
    hi_sel   = (state_q == S_FIX) ? hi_q : d_in;
    idx_sum  = {1'b0, base_lo} + {1'b0, idx};
    carry    = idx_sum[8];
    need_fix = store_q | (PAGE_PENALTY & carry);
    idx_ea   = wide16({hi_sel, base_lo}) + wide16({8'h00, idx});
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    store_d    = store_q;
    x_d        = x_q;
    y_d        = y_q;
    pcl_d      = pcl_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    ea_d       = ea_q;
    pcx_d      = pcx_q;
    addr_c     = '0;
    pc_inc_c   = 1'b0;
    ea_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_c = pc_in;
        if (start && rdy) begin
          mode_d  = mode;
          store_d = store;
          x_d     = x;
          y_d     = y;
          pcl_d   = pc_in;
          if (mode == M_IMM) begin
            state_d = S_DONE;
            ea_d    = pc_in;
            pcx_d   = 1'b0;
          end else begin
            state_d = S_FETCH_LO;
          end
        end
      end
      S_FETCH_LO: begin
        addr_c   = pcl_q;
        pc_inc_c = rdy;
        if (rdy) begin
          lo_d = d_in;
          case (mode_q)
            M_ZPG: begin
              state_d = S_DONE;
              ea_d    = zp_addr(d_in, 8'h00, 1'b0);
              pcx_d   = 1'b0;
            end
            M_ZPX, M_INX: state_d = S_INDEX;
            M_INY:        state_d = S_PTR_LO;
            default:      state_d = S_FETCH_HI;
          endcase
        end
      end
      S_FETCH_HI: begin
        addr_c   = pcl_q + ADDR_W'(1);
        pc_inc_c = rdy;
        if (rdy) begin
          hi_d = d_in;
          if (mode_q == M_ABS) begin
            state_d = S_DONE;
            ea_d    = wide16({d_in, lo_q});
            pcx_d   = 1'b0;
          end else if (need_fix) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DONE;
            ea_d    = idx_ea;
            pcx_d   = carry;
          end
        end
      end
      S_INDEX: begin
        addr_c = zp_addr(lo_q, 8'h00, 1'b0);
        if (rdy) begin
          if (mode_q == M_ZPX) begin
            state_d = S_DONE;
            ea_d    = zp_addr(lo_q, x_q, 1'b0);
            pcx_d   = 1'b0;
          end else begin
            state_d = S_PTR_LO;
          end
        end
      end
      S_PTR_LO: begin
        addr_c = (mode_q == M_INX) ? zp_addr(lo_q, x_q, 1'b0) : zp_addr(lo_q, 8'h00, 1'b0);
        if (rdy) begin
          ptr_d   = d_in;
          state_d = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        addr_c = (mode_q == M_INX) ? zp_addr(lo_q, x_q, 1'b1) : zp_addr(lo_q, 8'h00, 1'b1);
        if (rdy) begin
          hi_d = d_in;
          if (mode_q == M_INX) begin
            state_d = S_DONE;
            ea_d    = wide16({d_in, ptr_q});
            pcx_d   = 1'b0;
          end else if (need_fix) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DONE;
            ea_d    = idx_ea;
            pcx_d   = carry;
          end
        end
      end
      S_FIX: begin
        addr_c = wide16({hi_q, idx_sum[7:0]});
        if (rdy) begin
          state_d = S_DONE;
          ea_d    = idx_ea;
          pcx_d   = carry;
        end
      end
      S_DONE: begin
        addr_c     = ea_q;
        ea_valid_c = 1'b1;
        pc_inc_c   = rdy & (mode_q == M_IMM);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      store_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      pcl_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ptr_q   <= '0;
      ea_q    <= '0;
      pcx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      store_q <= store_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pcl_q   <= pcl_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      ea_q    <= ea_d;
      pcx_q   <= pcx_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after it releases.
  assign addr       = rst ? addr_c : '0;
  assign pc_inc     = rst & pc_inc_c;
  assign busy       = (state_q != S_IDLE);
  assign ea         = ea_q;
  assign ea_valid   = ea_valid_c;
  assign page_cross = pcx_q;
endmodule

// File: tb/tb_cpu_addr_seq.sv
// tb/tb_cpu_addr_seq.sv - scoreboard bench for cpu_addr_seq
// Reference model computes bus steps and ea from a byte memory; a negedge monitor checks the DUT.
module tb_cpu_addr_seq;
  typedef struct packed {
    logic [15:0] a;
    logic        pc;
  } step_t;

  typedef struct packed {
    logic [15:0] ea;
    logic        pcx;
    logic [7:0]  steps;
    logic [7:0]  npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        start = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [7:0]  x = 8'h00;
  logic [7:0]  y = 8'h00;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  d_in;
  logic [15:0] addr;
  logic [15:0] ea;
  logic        pc_inc, busy, ea_valid, page_cross;

  logic [7:0]  mem [0:65535];
  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          npc = 0;
  int          last_total = 0;
  logic [15:0] last_ea = 16'h0000;
  logic        last_pcx = 1'b0;
  step_t       exp_addr_q[$];
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  assign d_in = mem[addr];

  cpu_addr_seq #(.ADDR_W(16), .ZP_WRAP(1'b1), .PAGE_PENALTY(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .start(start), .mode(mode), .store(store),
    .x(x), .y(y), .pc_in(pc_in), .d_in(d_in), .addr(addr), .pc_inc(pc_inc),
    .busy(busy), .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic tfail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push_step(input logic [15:0] a, input logic p);
    step_t s;
    s.a  = a;
    s.pc = p;
    exp_addr_q.push_back(s);
  endtask

  // Reference: expected bus steps and result straight from the addressing-mode rules.
  task automatic model_push(input logic [2:0] m, input logic st, input logic [7:0] xx,
                            input logic [7:0] yy, input logic [15:0] pc);
    logic [7:0]  b0, b1, p, q, idx, plo, phi;
    logic [15:0] base;
    exp_t        e;
    int          n0;
    n0    = exp_addr_q.size();
    b0    = mem[pc];
    b1    = mem[pc + 16'd1];
    e.pcx = 1'b0;
    e.npc = 8'd1;
    e.ea  = 16'h0000;
    idx   = (m == 3'b111) ? xx : yy;
    case (m)
      3'b010: e.ea = pc;
      3'b001: begin
        push_step(pc, 1'b1);
        e.ea = {8'h00, b0};
      end
      3'b101: begin
        push_step(pc, 1'b1);
        push_step({8'h00, b0}, 1'b0);
        p = b0 + xx;
        e.ea = {8'h00, p};
      end
      3'b011: begin
        push_step(pc, 1'b1);
        push_step(pc + 16'd1, 1'b1);
        e.npc = 8'd2;
        e.ea = {b1, b0};
      end
      3'b110, 3'b111: begin
        push_step(pc, 1'b1);
        push_step(pc + 16'd1, 1'b1);
        e.npc = 8'd2;
        base  = {b1, b0};
        e.pcx = (({1'b0, b0} + {1'b0, idx}) > 9'h0FF);
        e.ea  = base + {8'h00, idx};
        p = b0 + idx;
        if (st || e.pcx) push_step({b1, p}, 1'b0);
      end
      3'b000: begin
        push_step(pc, 1'b1);
        push_step({8'h00, b0}, 1'b0);
        p = b0 + xx;
        q = p + 8'd1;
        push_step({8'h00, p}, 1'b0);
        push_step({8'h00, q}, 1'b0);
        e.ea = {mem[{8'h00, q}], mem[{8'h00, p}]};
      end
      default: begin
        push_step(pc, 1'b1);
        push_step({8'h00, b0}, 1'b0);
        q = b0 + 8'd1;
        push_step({8'h00, q}, 1'b0);
        plo   = mem[{8'h00, b0}];
        phi   = mem[{8'h00, q}];
        base  = {phi, plo};
        e.pcx = (({1'b0, plo} + {1'b0, yy}) > 9'h0FF);
        e.ea  = base + {8'h00, yy};
        p = plo + yy;
        if (st || e.pcx) push_step({phi, p}, 1'b0);
      end
    endcase
    e.steps = 8'(exp_addr_q.size() - n0);
    exp_q.push_back(e);
  endtask

  task automatic issue_start(input logic [2:0] m, input logic st, input logic [7:0] xx,
                             input logic [7:0] yy, input logic [15:0] pc);
    int g;
    g = 0;
    while (busy) begin
      @(posedge clk); #1;
      g++;
      if (g > 300) begin
        tfail("idle_timeout");
        return;
      end
    end
    mode = m; store = st; x = xx; y = yy; pc_in = pc;
    start = 1'b1;
    g = 0;
    forever begin
      @(posedge clk);
      if (rdy) break;
      g++;
      if (g > 300) begin
        tfail("accept_timeout");
        #1 start = 1'b0;
        return;
      end
    end
    model_push(m, st, xx, yy, pc);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(posedge clk); #1;
    while (busy) begin
      @(posedge clk); #1;
      g++;
      if (g > 300) begin
        tfail("done_timeout");
        return;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) rdy = 1'b1;
    else if (rdy_mode == 1) rdy = ea_valid ? 1'b1 : ($urandom_range(0, 9) < 7);
  end

  always @(negedge clk) begin
    step_t h;
    exp_t  e;
    if (!rst) begin
      cyc = 0; stalls = 0; npc = 0;
    end else if (ea_valid) begin
      cyc++;
      if (pc_inc) npc++;
      if (exp_q.size() == 0) begin
        tfail("unexpected_ea_valid");
      end else begin
        e = exp_q.pop_front();
        chk("ea", 32'(ea), 32'(e.ea));
        chk("done_addr", 32'(addr), 32'(e.ea));
        chk("page_cross", 32'(page_cross), 32'(e.pcx));
        chk("pc_inc_count", 32'(npc), 32'(e.npc));
        chk("steps", 32'(cyc - 1 - stalls), 32'(e.steps));
        chk("steps_left", 32'(exp_addr_q.size()), 32'd0);
        last_total = cyc;
        last_ea    = ea;
        last_pcx   = page_cross;
      end
      cyc = 0; stalls = 0; npc = 0;
    end else if (busy) begin
      cyc++;
      if (pc_inc) npc++;
      if (exp_addr_q.size() == 0) begin
        tfail("extra_busy_cycle");
      end else begin
        h = exp_addr_q[0];
        chk("bus_addr", 32'(addr), 32'(h.a));
        chk("pc_inc", 32'(pc_inc), 32'(rdy & h.pc));
        if (rdy) void'(exp_addr_q.pop_front());
        else stalls++;
      end
    end else begin
      cyc = 0; stalls = 0; npc = 0;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    #3;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ea", 32'(ea), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_ea_valid", 32'(ea_valid), 32'd0);
    chk("rst_page_cross", 32'(page_cross), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    pc_in = 16'hABCD;
    #1 chk("idle_passthrough", 32'(addr), 32'h0000ABCD);
    @(posedge clk); #1;

    mem[16'h8000] = 8'h20;
    issue_start(3'b101, 1'b0, 8'hF0, 8'h00, 16'h8000);
    wait_idle();
    chk("zpx_ea", 32'(last_ea), 32'h0010);
    chk("zpx_latency", 32'(last_total), 32'd3);

    mem[16'h9000] = 8'hFF; mem[16'h9001] = 8'h12;
    issue_start(3'b111, 1'b0, 8'h01, 8'h00, 16'h9000);
    wait_idle();
    chk("abx_cross_ea", 32'(last_ea), 32'h1300);
    chk("abx_cross_pcx", 32'(last_pcx), 32'd1);
    chk("abx_cross_latency", 32'(last_total), 32'd4);

    mem[16'h9010] = 8'h10; mem[16'h9011] = 8'h12;
    issue_start(3'b111, 1'b0, 8'h01, 8'h00, 16'h9010);
    wait_idle();
    chk("abx_nocross_ea", 32'(last_ea), 32'h1211);
    chk("abx_nocross_pcx", 32'(last_pcx), 32'd0);
    chk("abx_nocross_latency", 32'(last_total), 32'd3);

    mem[16'h9020] = 8'h00; mem[16'h9021] = 8'h30;
    issue_start(3'b110, 1'b1, 8'h00, 8'h00, 16'h9020);
    wait_idle();
    chk("sta_aby_ea", 32'(last_ea), 32'h3000);
    chk("sta_aby_pcx", 32'(last_pcx), 32'd0);
    chk("sta_aby_latency", 32'(last_total), 32'd4);

    mem[16'h9030] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    issue_start(3'b000, 1'b0, 8'h01, 8'h00, 16'h9030);
    wait_idle();
    chk("inx_ea", 32'(last_ea), 32'h1234);
    chk("inx_latency", 32'(last_total), 32'd5);

    mem[16'h9040] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h20;
    rdy_mode = 3;
    issue_start(3'b100, 1'b0, 8'h00, 8'h05, 16'h9040);
    @(posedge clk); #1 rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    wait_idle();
    rdy_mode = 0;
    chk("iny_stall_ea", 32'(last_ea), 32'h20F5);
    chk("iny_stall_latency", 32'(last_total), 32'd7);

    issue_start(3'b000, 1'b0, 8'h01, 8'h00, 16'h9030);
    mode = 3'b010; pc_in = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    chk("busy_start_ea", 32'(last_ea), 32'h1234);
    chk("busy_start_latency", 32'(last_total), 32'd5);

    mem[16'h9050] = 8'h11; mem[16'h9051] = 8'h22;
    issue_start(3'b011, 1'b0, 8'h00, 8'h00, 16'h9050);
    @(posedge clk); #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pc_inc", 32'(pc_inc), 32'd0);
    chk("abort_ea", 32'(ea), 32'd0);
    chk("abort_page_cross", 32'(page_cross), 32'd0);
    chk("abort_ea_valid", 32'(ea_valid), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #2 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    rdy_mode = 1;
    repeat (200) begin
      issue_start(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
